// File: rtl/wl_pkg.sv
// Shared request/response types, address-rule type and memory map for the wl core data path.
package wl_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    localparam logic [AddrWidth-1:0] BootromBase  = 32'h0000_0000;
    localparam logic [AddrWidth-1:0] SramBase     = 32'h0001_0000;
    localparam logic [AddrWidth-1:0] PeriphBase   = 32'h0002_0000;
    localparam logic [AddrWidth-1:0] AccelBase    = 32'h0004_0000;
    localparam logic [AddrWidth-1:0] HwpeCfgBase  = 32'h0008_0000;
    localparam logic [AddrWidth-1:0] Region64kMask = 32'hFFFF_0000;

    localparam int unsigned PortBootrom   = 0;
    localparam int unsigned PortSram      = 1;
    localparam int unsigned PortPeriph    = 2;
    localparam int unsigned PortAccel     = 3;
    localparam int unsigned PortHwpeCfg   = 4;
    localparam int unsigned NumDemuxPorts = 5;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } core_data_q_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 error;
    } core_data_p_t;

    typedef struct packed {
        core_data_q_t q;
        logic         q_valid;
        logic         p_ready;
    } core_data_req_t;

    typedef struct packed {
        core_data_p_t p;
        logic         p_valid;
        logic         q_ready;
    } core_data_rsp_t;

    typedef struct packed {
        logic [31:0]          idx;
        logic [AddrWidth-1:0] base;
        logic [AddrWidth-1:0] mask;
    } addr_napot_demux_rule_t;

    function automatic logic napot_match(input logic [AddrWidth-1:0] addr,
                                         input addr_napot_demux_rule_t rule);
        return (addr & rule.mask) == (rule.base & rule.mask);
    endfunction

endpackage

// File: rtl/wl_route_fifo.sv
// Small FIFO holding the route of each outstanding request; full blocks pushes even when popping.
module wl_route_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 4,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wl_reqrsp_napot_demux.sv
// Routes reqrsp requests to downstream ports by NAPOT address rules and returns responses in request order.
module wl_reqrsp_napot_demux
    import wl_pkg::*;
#(
    parameter int unsigned NumPorts = 5,
    parameter int unsigned MaxTrans = 4,
    parameter int unsigned NumRules = 5,
    parameter type req_t = wl_pkg::core_data_req_t,
    parameter type rsp_t = wl_pkg::core_data_rsp_t
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  addr_napot_demux_rule_t [NumRules-1:0] rules_i,
    input  req_t                                  slv_req_i,
    output rsp_t                                  slv_rsp_o,
    output req_t [NumPorts-1:0]                   mst_req_o,
    input  rsp_t [NumPorts-1:0]                   mst_rsp_i,
    output logic                                  busy_o,
    output logic [15:0]                           dec_err_cnt_o
);

    localparam int unsigned PortW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned RouteW = PortW + 1;
    localparam int unsigned CntW   = $clog2(MaxTrans + 1);

    typedef logic [PortW-1:0] port_idx_t;

    port_idx_t         dec_port;
    logic              dec_err;
    port_idx_t         head_port;
    logic              head_err;
    logic [RouteW-1:0] head_route;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic              accept_ok;
    logic              tgt_q_ready;
    logic              head_p_valid;
    logic              push;
    logic              pop;

    // Reverse scan so the lowest-numbered matching rule is the one left standing.
    always_comb begin
        dec_port = '0;
        dec_err  = 1'b1;
        for (int r = NumRules - 1; r >= 0; r--) begin
            if (napot_match(slv_req_i.q.addr, rules_i[r])) begin
                dec_err  = (rules_i[r].idx >= 32'(NumPorts));
                dec_port = port_idx_t'(rules_i[r].idx);
            end
        end
    end

    assign accept_ok = ~fifo_full & ~rst_i;
    assign {head_port, head_err} = head_route;

    always_comb begin
        mst_req_o    = '0;
        slv_rsp_o    = '0;
        tgt_q_ready  = 1'b0;
        head_p_valid = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            mst_req_o[i].q       = slv_req_i.q;
            mst_req_o[i].q_valid = slv_req_i.q_valid & accept_ok & ~dec_err
                                   & (dec_port == port_idx_t'(i));
            mst_req_o[i].p_ready = slv_req_i.p_ready & ~fifo_empty & ~head_err
                                   & (head_port == port_idx_t'(i));
            if (dec_port == port_idx_t'(i)) tgt_q_ready = mst_rsp_i[i].q_ready;
            if (head_port == port_idx_t'(i)) begin
                head_p_valid = mst_rsp_i[i].p_valid;
                slv_rsp_o.p  = mst_rsp_i[i].p;
            end
        end
        if (head_err) begin
            slv_rsp_o.p.data  = '0;
            slv_rsp_o.p.error = 1'b1;
        end
        slv_rsp_o.q_ready = accept_ok & (dec_err | tgt_q_ready);
        slv_rsp_o.p_valid = ~fifo_empty & (head_err | head_p_valid);
    end

    assign push = slv_req_i.q_valid & slv_rsp_o.q_ready;
    assign pop  = slv_rsp_o.p_valid & slv_req_i.p_ready;

    wl_route_fifo #(
        .Depth (MaxTrans),
        .Width (RouteW)
    ) i_route_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata ({dec_port, dec_err}),
        .pop   (pop),
        .rdata (head_route),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy_o = (fifo_count != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_err_cnt_o <= '0;
        end else if (push && dec_err && dec_err_cnt_o != 16'hFFFF) begin
            dec_err_cnt_o <= dec_err_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_wl_reqrsp_napot_demux.sv
// Directed bench for the NAPOT demux: queue-based route model checked every cycle plus literal spot checks.
module tb_wl_reqrsp_napot_demux;
    import wl_pkg::*;

    localparam int NP = 5;
    localparam int MT = 4;
    localparam int NR = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    addr_napot_demux_rule_t [NR-1:0] rules;
    core_data_req_t                  slv_req;
    core_data_rsp_t                  slv_rsp;
    core_data_req_t [NP-1:0]         mst_req;
    core_data_rsp_t [NP-1:0]         mst_rsp;
    logic                            busy;
    logic [15:0]                     err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wl_reqrsp_napot_demux #(
        .NumPorts (NP),
        .MaxTrans (MT),
        .NumRules (NR)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rules_i       (rules),
        .slv_req_i     (slv_req),
        .slv_rsp_o     (slv_rsp),
        .mst_req_o     (mst_req),
        .mst_rsp_i     (mst_rsp),
        .busy_o        (busy),
        .dec_err_cnt_o (err_cnt)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: the list of outstanding routes in request order (-1 = decode error).
    int  mq[$];
    int  merr = 0;
    bit  do_push, do_pop;
    int  push_val;

    function automatic int model_decode(input logic [31:0] a);
        for (int r = 0; r < NR; r++) begin
            if ((a & rules[r].mask) == (rules[r].base & rules[r].mask))
                return (rules[r].idx < NP) ? int'(rules[r].idx) : -1;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            merr    = 0;
            do_push = 0;
            do_pop  = 0;
            chk("m_rst_busy", busy, 0);
            chk("m_rst_cnt", err_cnt, 0);
            chk("m_rst_pvalid", slv_rsp.p_valid, 0);
            for (int i = 0; i < NP; i++) chk("m_rst_qvalid", mst_req[i].q_valid, 0);
        end else begin
            bit full, exp_qr, exp_pv;
            int dec, head;
            full   = (mq.size() >= MT);
            dec    = model_decode(slv_req.q.addr);
            head   = (mq.size() > 0) ? mq[0] : -2;
            exp_qr = !full && (dec < 0 || mst_rsp[dec].q_ready);
            exp_pv = (mq.size() > 0) && (head == -1 || mst_rsp[head].p_valid);
            chk("m_busy", busy, (mq.size() != 0));
            chk("m_errcnt", err_cnt, merr);
            chk("m_qready", slv_rsp.q_ready, exp_qr);
            chk("m_pvalid", slv_rsp.p_valid, exp_pv);
            if (exp_pv) begin
                chk("m_pdata", slv_rsp.p.data, (head < 0) ? 0 : mst_rsp[head].p.data);
                chk("m_perror", slv_rsp.p.error, (head < 0) ? 1 : mst_rsp[head].p.error);
            end
            for (int i = 0; i < NP; i++) begin
                bit exp_qv;
                exp_qv = slv_req.q_valid && !full && dec == i;
                chk("m_mst_qvalid", mst_req[i].q_valid, exp_qv);
                if (exp_qv) chk("m_mst_addr", mst_req[i].q.addr, slv_req.q.addr);
                chk("m_mst_pready", mst_req[i].p_ready, (head == i) && slv_req.p_ready);
            end
            do_push  = slv_req.q_valid && exp_qr;
            push_val = dec;
            do_pop   = exp_pv && slv_req.p_ready;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(push_val);
                if (push_val < 0 && merr < 65535) merr++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rules_default();
        for (int r = 0; r < NR; r++) rules[r].idx = r;
        rules[0].base = BootromBase;
        rules[1].base = SramBase;
        rules[2].base = PeriphBase;
        rules[3].base = AccelBase;
        rules[4].base = HwpeCfgBase;
        for (int r = 0; r < NR; r++) rules[r].mask = Region64kMask;
    endtask

    task automatic request(input logic [31:0] addr, input logic write);
        slv_req.q.addr  = addr;
        slv_req.q.write = write;
        slv_req.q.data  = 32'h1234_0000 | addr[15:0];
        slv_req.q.strb  = 4'hF;
        slv_req.q_valid = 1'b1;
    endtask

    initial begin
        slv_req = '0;
        mst_rsp = '0;
        for (int i = 0; i < NP; i++) begin
            mst_rsp[i].q_ready = 1'b1;
            mst_rsp[i].p.data  = 32'hD000_0000 | i;
        end
        set_rules_default();
        repeat (2) tick();
        chk("reset_busy", busy, 0);
        chk("reset_errcnt", err_cnt, 0);
        chk("reset_qvalid2", mst_req[2].q_valid, 0);
        rst = 1'b0;
        tick();

        // read to periph region
        request(32'h0002_0004, 1'b0);
        #1;
        chk("s1_qvalid2", mst_req[2].q_valid, 1);
        chk("s1_qvalid0", mst_req[0].q_valid, 0);
        chk("s1_qready", slv_rsp.q_ready, 1);
        tick();
        slv_req.q_valid       = 1'b0;
        mst_rsp[2].p.data     = 32'hCAFE_0002;
        mst_rsp[2].p_valid    = 1'b1;
        slv_req.p_ready       = 1'b1;
        #1;
        chk("s1_pvalid", slv_rsp.p_valid, 1);
        chk("s1_pdata", slv_rsp.p.data, 32'hCAFE_0002);
        chk("s1_pready2", mst_req[2].p_ready, 1);
        tick();
        mst_rsp[2].p_valid = 1'b0;
        slv_req.p_ready    = 1'b0;

        // unmapped write
        request(32'h0003_0000, 1'b1);
        #1;
        chk("s2_qready", slv_rsp.q_ready, 1);
        chk("s2_pvalid_same_cycle", slv_rsp.p_valid, 0);
        tick();
        slv_req.q_valid = 1'b0;
        #1;
        chk("s2_pvalid", slv_rsp.p_valid, 1);
        chk("s2_perror", slv_rsp.p.error, 1);
        chk("s2_pdata", slv_rsp.p.data, 0);
        chk("s2_errcnt", err_cnt, 1);
        slv_req.p_ready = 1'b1;
        tick();
        slv_req.p_ready = 1'b0;
        #1;
        chk("s2_busy_after", busy, 0);

        // order: port 3 then port 0, port 0 answers first
        request(32'h0004_0000, 1'b0);
        tick();
        request(32'h0000_0100, 1'b0);
        tick();
        slv_req.q_valid    = 1'b0;
        mst_rsp[0].p_valid = 1'b1;
        slv_req.p_ready    = 1'b1;
        #1;
        chk("s3_pready0_held", mst_req[0].p_ready, 0);
        chk("s3_pvalid_wait", slv_rsp.p_valid, 0);
        tick();
        mst_rsp[3].p_valid = 1'b1;
        #1;
        chk("s3_pready3", mst_req[3].p_ready, 1);
        chk("s3_pready0_still", mst_req[0].p_ready, 0);
        chk("s3_data3", slv_rsp.p.data, 32'hD000_0003);
        tick();
        mst_rsp[3].p_valid = 1'b0;
        #1;
        chk("s3_pready0", mst_req[0].p_ready, 1);
        chk("s3_data0", slv_rsp.p.data, 32'hD000_0000);
        tick();
        mst_rsp[0].p_valid = 1'b0;
        slv_req.p_ready    = 1'b0;

        // capacity: 5 back-to-back with responses stalled
        request(32'h0001_0000, 1'b1);
        repeat (4) tick();
        chk("s4_qready_full", slv_rsp.q_ready, 0);
        chk("s4_busy", busy, 1);
        chk("s4_qvalid1_gated", mst_req[1].q_valid, 0);
        mst_rsp[1].p_valid = 1'b1;
        slv_req.p_ready    = 1'b1;
        #1;
        chk("s4_pvalid", slv_rsp.p_valid, 1);
        chk("s4_no_push_when_full", slv_rsp.q_ready, 0);
        tick();
        slv_req.p_ready = 1'b0;
        #1;
        chk("s4_qready_released", slv_rsp.q_ready, 1);
        tick();
        slv_req.q_valid = 1'b0;
        slv_req.p_ready = 1'b1;
        repeat (4) tick();
        mst_rsp[1].p_valid = 1'b0;
        slv_req.p_ready    = 1'b0;
        #1;
        chk("s4_drained", busy, 0);

        // overlapping rules and an out-of-range idx
        rules[0].mask = 32'hFFFE_0000;
        rules[4].idx  = 7;
        request(32'h0001_0000, 1'b0);
        #1;
        chk("s5_rule0_wins", mst_req[0].q_valid, 1);
        chk("s5_rule1_loses", mst_req[1].q_valid, 0);
        tick();
        request(32'h0008_0000, 1'b0);
        #1;
        chk("s5_badidx_qvalid4", mst_req[4].q_valid, 0);
        chk("s5_badidx_qready", slv_rsp.q_ready, 1);
        tick();
        slv_req.q_valid    = 1'b0;
        mst_rsp[0].p_valid = 1'b1;
        slv_req.p_ready    = 1'b1;
        tick();
        mst_rsp[0].p_valid = 1'b0;
        #1;
        chk("s5_badidx_perror", slv_rsp.p.error, 1);
        chk("s5_errcnt", err_cnt, 2);
        tick();
        slv_req.p_ready = 1'b0;
        set_rules_default();

        // reset mid-burst with 3 outstanding
        request(32'h0004_0000, 1'b0);
        repeat (3) tick();
        chk("s6_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_busy_async", busy, 0);
        chk("s6_errcnt_async", err_cnt, 0);
        chk("s6_qvalid3_rst", mst_req[3].q_valid, 0);
        chk("s6_qready_rst", slv_rsp.q_ready, 0);
        tick();
        slv_req.q_valid    = 1'b0;
        rst                = 1'b0;
        mst_rsp[3].p_valid = 1'b1;
        slv_req.p_ready    = 1'b1;
        #1;
        chk("s6_late_pready3", mst_req[3].p_ready, 0);
        chk("s6_late_pvalid", slv_rsp.p_valid, 0);
        tick();
        mst_rsp[3].p_valid = 1'b0;
        slv_req.p_ready    = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
